// File: rtl/chip8_sprite_draw.sv
// rtl/chip8_sprite_draw.sv - CHIP-8 DXYN sprite draw engine (XOR blit into 64x32 display buffer)
module chip8_sprite_draw #(
    parameter logic [11:0] DISPLAY_BASE = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] sprite_addr,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [3:0]  n,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        mem_read,
    output logic [11:0] mem_read_addr,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_read_ack,
    output logic        mem_write,
    output logic [11:0] mem_write_addr,
    output logic [7:0]  mem_write_data
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] RD_S = 4'd1;
    localparam logic [3:0] WT_S = 4'd2;
    localparam logic [3:0] RD_L = 4'd3;
    localparam logic [3:0] WT_L = 4'd4;
    localparam logic [3:0] WR_L = 4'd5;
    localparam logic [3:0] RD_R = 4'd6;
    localparam logic [3:0] WT_R = 4'd7;
    localparam logic [3:0] WR_R = 4'd8;
    localparam logic [3:0] DONE = 4'd9;

    logic [3:0]  state;
    logic [11:0] spr_base;
    logic [5:0]  xo;
    logic [4:0]  yo;
    logic [3:0]  n_rows;
    logic [3:0]  row;
    logic [7:0]  spr;
    logic [7:0]  old;

    logic [15:0] shifted;
    logic [7:0]  pat_l;
    logic [7:0]  pat_r;
    logic [4:0]  disp_row;
    logic [2:0]  col_l;
    logic [2:0]  col_r;
    logic [11:0] addr_l;
    logic [11:0] addr_r;
    logic [3:0]  row_adv_state;
    logic        unused_hi;

    // Coordinates are taken mod 64/32, so the upper bits of Vx/Vy never matter.
    assign unused_hi = ^{x[7:6], y[7:5]};

    // One wide shift yields both halves: the left byte's pattern in the top,
    // the spill into the next byte column in the bottom.
    assign shifted  = {spr, 8'h00} >> xo[2:0];
    assign pat_l    = shifted[15:8];
    assign pat_r    = shifted[7:0];
    assign disp_row = yo + {1'b0, row};
    assign col_l    = xo[5:3];
    assign col_r    = col_l + 3'd1;
    assign addr_l   = DISPLAY_BASE + {4'd0, disp_row, col_l};
    assign addr_r   = DISPLAY_BASE + {4'd0, disp_row, col_r};

    // Row advance is folded into the final write of each row.
    assign row_adv_state = (({1'b0, row} + 5'd1) < {1'b0, n_rows}) ? RD_S : DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            spr_base  <= 12'd0;
            xo        <= 6'd0;
            yo        <= 5'd0;
            n_rows    <= 4'd0;
            row       <= 4'd0;
            spr       <= 8'd0;
            old       <= 8'd0;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        spr_base  <= sprite_addr;
                        xo        <= x[5:0];
                        yo        <= y[4:0];
                        n_rows    <= n;
                        row       <= 4'd0;
                        collision <= 1'b0;
                        state     <= (n == 4'd0) ? DONE : RD_S;
                    end
                end
                RD_S: state <= WT_S;
                WT_S: begin
                    if (mem_read_ack) begin
                        spr   <= mem_read_data;
                        state <= RD_L;
                    end
                end
                RD_L: state <= WT_L;
                WT_L: begin
                    if (mem_read_ack) begin
                        old   <= mem_read_data;
                        state <= WR_L;
                    end
                end
                WR_L: begin
                    collision <= collision | (|(old & pat_l));
                    if (xo[2:0] != 3'd0) begin
                        state <= RD_R;
                    end else begin
                        row   <= row + 4'd1;
                        state <= row_adv_state;
                    end
                end
                RD_R: state <= WT_R;
                WT_R: begin
                    if (mem_read_ack) begin
                        old   <= mem_read_data;
                        state <= WR_R;
                    end
                end
                WR_R: begin
                    collision <= collision | (|(old & pat_r));
                    row       <= row + 4'd1;
                    state     <= row_adv_state;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_read_addr  = 12'd0;
        mem_write      = 1'b0;
        mem_write_addr = 12'd0;
        mem_write_data = 8'd0;
        case (state)
            RD_S: begin
                mem_read      = 1'b1;
                mem_read_addr = spr_base + {8'd0, row};
            end
            RD_L: begin
                mem_read      = 1'b1;
                mem_read_addr = addr_l;
            end
            RD_R: begin
                mem_read      = 1'b1;
                mem_read_addr = addr_r;
            end
            WR_L: begin
                mem_write      = 1'b1;
                mem_write_addr = addr_l;
                mem_write_data = old ^ pat_l;
            end
            WR_R: begin
                mem_write      = 1'b1;
                mem_write_addr = addr_r;
                mem_write_data = old ^ pat_r;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule
